// File: rtl/axi4_lite_read_arbiter.sv
// axi4_lite_read_arbiter: N-master to 1-slave AXI4-Lite read-path arbiter.
// One outstanding read; the grant is held from AR handshake to R handshake.
// Optional feature macro AXIL_RD_ARB_ROUND_ROBIN_EN selects round-robin
// priority; without it the lowest requesting index always wins.
module axi4_lite_read_arbiter #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned NUM_MASTERS   = 4
) (
  input  logic                                 ACLK,
  input  logic                                 ARESET,
  input  logic [NUM_MASTERS*ADDRESS_WIDTH-1:0] S_AXI_ARADDR,
  input  logic [NUM_MASTERS-1:0]               S_AXI_ARVALID,
  output logic [NUM_MASTERS-1:0]               S_AXI_ARREADY,
  output logic [NUM_MASTERS*DATA_WIDTH-1:0]    S_AXI_RDATA,
  output logic [NUM_MASTERS*2-1:0]             S_AXI_RRESP,
  output logic [NUM_MASTERS-1:0]               S_AXI_RVALID,
  input  logic [NUM_MASTERS-1:0]               S_AXI_RREADY,
  output logic [ADDRESS_WIDTH-1:0]             M_AXI_ARADDR,
  output logic                                 M_AXI_ARVALID,
  input  logic                                 M_AXI_ARREADY,
  input  logic [DATA_WIDTH-1:0]                M_AXI_RDATA,
  input  logic [1:0]                           M_AXI_RRESP,
  input  logic                                 M_AXI_RVALID,
  output logic                                 M_AXI_RREADY,
  output logic [$clog2(NUM_MASTERS)-1:0]       GRANT,
  output logic                                 BUSY
);

  localparam int unsigned GW = $clog2(NUM_MASTERS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic [GW-1:0]            grant_q, grant_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic                     arvalid_q, arvalid_d;
  logic                     busy_q, busy_d;

`ifdef AXIL_RD_ARB_ROUND_ROBIN_EN
  logic [GW-1:0]            ptr_q, ptr_d;
  logic [GW-1:0]            hi_idx;
  logic                     hi_vld;
`endif

  logic [GW-1:0]            lo_idx;
  logic                     lo_vld;
  logic [GW-1:0]            win;
  logic                     win_vld;
  logic [ADDRESS_WIDTH-1:0] win_addr;

  // Arbitration: first requester at or above the pointer, else lowest requester.
  always_comb begin
    lo_idx   = '0;
    lo_vld   = 1'b0;
    win_addr = '0;
`ifdef AXIL_RD_ARB_ROUND_ROBIN_EN
    hi_idx   = '0;
    hi_vld   = 1'b0;
`endif
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (S_AXI_ARVALID[i] && !lo_vld) begin
        lo_vld = 1'b1;
        lo_idx = GW'(i);
      end
`ifdef AXIL_RD_ARB_ROUND_ROBIN_EN
      if (S_AXI_ARVALID[i] && !hi_vld && (GW'(i) >= ptr_q)) begin
        hi_vld = 1'b1;
        hi_idx = GW'(i);
      end
`endif
    end
`ifdef AXIL_RD_ARB_ROUND_ROBIN_EN
    win = hi_vld ? hi_idx : lo_idx;
`else
    win = lo_idx;
`endif
    win_vld = lo_vld;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (GW'(i) == win) begin
        win_addr = S_AXI_ARADDR[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      end
    end
  end

  // Upstream handshake and R-channel steering to the granted slot.
  always_comb begin
    S_AXI_ARREADY = '0;
    S_AXI_RDATA   = '0;
    S_AXI_RRESP   = '0;
    S_AXI_RVALID  = '0;
    M_AXI_RREADY  = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if ((state_q == ST_IDLE) && !ARESET && win_vld && (GW'(i) == win)) begin
        S_AXI_ARREADY[i] = 1'b1;
      end
      if ((state_q == ST_DATA) && (GW'(i) == grant_q)) begin
        S_AXI_RDATA[i*DATA_WIDTH +: DATA_WIDTH] = M_AXI_RDATA;
        S_AXI_RRESP[i*2 +: 2]                   = M_AXI_RRESP;
        S_AXI_RVALID[i]                         = M_AXI_RVALID;
        M_AXI_RREADY                            = S_AXI_RREADY[i];
      end
    end
  end

  // Next-state logic for the IDLE -> ADDR -> DATA read sequence.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    addr_d    = addr_q;
    arvalid_d = arvalid_q;
    busy_d    = busy_q;
`ifdef AXIL_RD_ARB_ROUND_ROBIN_EN
    ptr_d     = ptr_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (win_vld) begin
          state_d   = ST_ADDR;
          grant_d   = win;
          addr_d    = win_addr;
          arvalid_d = 1'b1;
          busy_d    = 1'b1;
        end
      end
      ST_ADDR: begin
        if (M_AXI_ARREADY) begin
          state_d   = ST_DATA;
          arvalid_d = 1'b0;
        end
      end
      ST_DATA: begin
        if (M_AXI_RVALID && M_AXI_RREADY) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
`ifdef AXIL_RD_ARB_ROUND_ROBIN_EN
          ptr_d   = (grant_q == GW'(NUM_MASTERS - 1)) ? '0 : grant_q + GW'(1);
`endif
        end
      end
      default: begin
        state_d   = ST_IDLE;
        arvalid_d = 1'b0;
        busy_d    = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset abandons any in-flight read.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      addr_q    <= '0;
      arvalid_q <= 1'b0;
      busy_q    <= 1'b0;
`ifdef AXIL_RD_ARB_ROUND_ROBIN_EN
      ptr_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      addr_q    <= addr_d;
      arvalid_q <= arvalid_d;
      busy_q    <= busy_d;
`ifdef AXIL_RD_ARB_ROUND_ROBIN_EN
      ptr_q     <= ptr_d;
`endif
    end
  end

  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARVALID = arvalid_q;
  assign GRANT         = grant_q;
  assign BUSY          = busy_q;

endmodule
